// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory path: responder FSM states,
// address alignment and the default geometry the CPU and benches agree on.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam int ADDR_ALIGN_BITS    = 2;
    localparam int DMEM_DEFAULT_DEPTH = 256;
    localparam int DMEM_DEFAULT_WAIT  = 2;
    localparam int DMEM_CNT_W         = 4;

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data memory: synchronous write, combinational read.
// Contents are deliberately left unreset.
module dmem_array
    import cpu_mem_pkg::*;
#(
    parameter  int DEPTH = DMEM_DEFAULT_DEPTH,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic [31:0]      rdata
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[widx] <= wdata;
        end
    end

    assign rdata = mem_q[ridx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding request, a fixed number
// of wait states, then a registered completion held until the initiator takes it.
module dmem_responder
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH       = DMEM_DEFAULT_DEPTH,
    parameter int WAIT_CYCLES = DMEM_DEFAULT_WAIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDX_W     = $clog2(DEPTH);
    localparam int HI_LSB    = ADDR_ALIGN_BITS + IDX_W;
    localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [DMEM_CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? DMEM_CNT_W'(WAIT_CYCLES - 1) : '0;

    dmem_state_e           state_q;
    logic [DMEM_CNT_W-1:0] cnt_q;
    logic                  write_q;
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;

    logic                  acc_fire_d;
    logic                  acc_write_d;
    logic [31:0]           acc_addr_d;
    logic [31:0]           acc_wdata_d;
    logic                  acc_err_d;
    logic [IDX_W-1:0]      acc_idx_d;
    logic                  mem_we_d;
    logic [31:0]           mem_rdata;
    logic [31:0]           acc_rdata_d;

    // With no wait states the access happens at the accepting edge, so it must
    // use the live request rather than the latches that are only loading then.
    always_comb begin
        acc_fire_d  = 1'b0;
        acc_write_d = write_q;
        acc_addr_d  = addr_q;
        acc_wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (ZERO_WAIT && req_valid && req_ready) begin
                    acc_fire_d  = 1'b1;
                    acc_write_d = req_write;
                    acc_addr_d  = req_addr;
                    acc_wdata_d = req_wdata;
                end
            end
            WAIT:    acc_fire_d = (cnt_q == '0);
            default: acc_fire_d = 1'b0;
        endcase
        acc_idx_d   = acc_addr_d[HI_LSB-1:ADDR_ALIGN_BITS];
        acc_err_d   = (acc_addr_d[ADDR_ALIGN_BITS-1:0] != '0) ||
                      (acc_addr_d[31:HI_LSB] != '0);
        mem_we_d    = acc_fire_d && acc_write_d && !acc_err_d;
        acc_rdata_d = (acc_err_d || acc_write_d) ? '0 : mem_rdata;
    end

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we_d),
        .widx  (acc_idx_d),
        .wdata (acc_wdata_d),
        .ridx  (acc_idx_d),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        write_q   <= req_write;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (ZERO_WAIT) begin
                            resp_valid <= 1'b1;
                            resp_rdata <= acc_rdata_d;
                            resp_err   <= acc_err_d;
                            state_q    <= RESP;
                        end else begin
                            cnt_q   <= CNT_INIT;
                            state_q <= WAIT;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= acc_rdata_d;
                        resp_err   <= acc_err_d;
                        state_q    <= RESP;
                    end else begin
                        cnt_q <= cnt_q - DMEM_CNT_W'(1);
                    end
                end
                RESP: begin
                    // Re-open for requests only after the handshake edge.
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the CPU's load/store path. It accepts one word request at a time over a valid/ready request channel and models a fixed number of wait states. It performs the read or write on an internal word array and returns a completion on a valid/ready response channel. It replaces the zero-latency combinational data memory when the CPU is extended with a stalling memory stage, and is the responder side of the CPU's load/store initiator.

## Interface
Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-low.

Parameters:
- `DEPTH`, 256: number of 32-bit words in the array (power of two, 4 to 65536).
- `WAIT_CYCLES`, 2: wait states between request acceptance and the array access (0 to 15).

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request; registered.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address; must be word-aligned.
- `req_wdata`  in  32  store data.
- `resp_valid`  out  1  completion present; registered.
- `resp_ready`  in  1  initiator accepts completion.
- `resp_rdata`  out  32  load data; 0 for stores and errors; registered.
- `resp_err`  out  1  misaligned or out-of-range access; registered.

## Operation
- FSM states are IDLE, WAIT and RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`&`req_ready`, latch write, addr and wdata, and drop `req_ready`.
  - If `WAIT_CYCLES`=0, perform the access at the same edge and go to RESP.
  - Otherwise load `cnt`=`WAIT_CYCLES`-1 and go to WAIT.
- **WAIT**
  - If `cnt`=0, perform the access and go to RESP.
  - Otherwise decrement `cnt`.
  - Request inputs are ignored.
- **Access**
  - The word index is `addr[2+log2(DEPTH)-1:2]`.
  - The access is an error if `addr[1:0]`≠0, or if any of `addr[31:2+log2(DEPTH)]` is nonzero.
  - On error: no write, `resp_err`=1, `resp_rdata`=0.
  - Load: `resp_rdata`=array word, `resp_err`=0.
  - Store: write the array, `resp_rdata`=0, `resp_err`=0.
  - `resp_valid` is set at the access edge.
- **RESP**
  - Hold `resp_valid`, `resp_rdata` and `resp_err` stable until `resp_valid`&`resp_ready`.
  - At that edge, clear all three outputs to 0, set `req_ready`=1 and go to IDLE.
- At most one outstanding transaction. No request is accepted in the same cycle that a response completes.
- Array contents are not reset; reads of never-written words return X in simulation.

## Timing
- Reset values while `rst`=0:
  - state IDLE, `cnt`=0;
  - `req_ready`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
- First rising edge with `rst`=1 sets `req_ready`=1. No request can be accepted at that edge.
- Let the accepting edge be edge 0:
  - the access happens at edge `WAIT_CYCLES`;
  - `resp_valid` is high from edge `WAIT_CYCLES` onward.
- With `resp_ready` tied high:
  - `resp_valid` lasts exactly 1 cycle;
  - `req_ready` returns 1 at edge `WAIT_CYCLES`+1;
  - the next request can be accepted at edge `WAIT_CYCLES`+2.
  - Peak throughput is therefore one transaction per `WAIT_CYCLES`+2 cycles.
- Store-then-load to the same address returns the stored value. The write has completed before the load can be accepted.
- Reset asserted mid-transaction aborts it immediately:
  - a store not yet at its access edge is dropped;
  - a store already performed stays in the array;
  - no response is issued.
- `req_*` inputs may change freely while `req_ready`=0.

## Structure
- Shared package `cpu_mem_pkg` holds:
  - the FSM state enum (IDLE, WAIT, RESP);
  - the address-alignment constant (2 bits);
  - the default depth and wait-state constants, so the CPU and testbench agree.
- Sub-module `dmem_array` contains the storage and is the only place the array is declared:
  - `DEPTH`×32 words, synchronous write on `clk`, combinational read;
  - ports `clk`, `we`, `widx`, `wdata`, `ridx`, `rdata`.
- `dmem_responder` contains the FSM, the counter, the request latches and the response registers.

## Test plan
- **Reset:** hold `rst`=0 with `req_valid`=1 for 3 cycles → all outputs 0 and the array is not written. The first edge after release sets `req_ready`=1.
- **Store/load, WAIT_CYCLES=2:**
  - store 0xDEADBEEF to 0x10 → `resp_valid` at edge 2 with `resp_err`=0, `resp_rdata`=0;
  - then load 0x10 → `resp_rdata`=0xDEADBEEF, `resp_err`=0.
- **Errors:**
  - load from 0x13 → `resp_err`=1, `resp_rdata`=0;
  - store to 0x400 with `DEPTH`=256 → `resp_err`=1, and a subsequent load of 0x0 is unchanged.
- **Backpressure:** hold `resp_ready`=0 for 5 cycles after `resp_valid` → data stays stable, `req_ready` stays 0, and a new request is not accepted until the cycle after the response handshake.
- **WAIT_CYCLES=0:** back-to-back loads with `resp_ready`=1 → `resp_valid` high the cycle after each accept, one accept every 2 cycles.
- **Mid-operation reset:** assert `rst` during WAIT of a store to 0x20 → no response. After release, a load of 0x20 returns its previous value.
